// File: rtl/edge_event_latch.sv
// Multi-channel edge event latch: per-channel synchroniser, glitch filter and
// mode-qualified edge detect feeding sticky W1C pending bits and a maskable irq.
module edge_event_latch #(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     irq_mask,
  input  logic [WIDTH-1:0]     clear,
  output logic [WIDTH-1:0]     level,
  output logic [WIDTH-1:0]     pending,
  output logic                 irq,
  output logic                 irq_edge
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0] arm_cnt;
  logic       armed;
  logic       irq_d;

  assign armed = &arm_cnt;

  // Level tracks the synchroniser unfiltered until armed, so inputs held
  // through reset never look like an edge.
  always_ff @(posedge clk) begin
    if (!rst_n)      arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 2'd1;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    logic          s1, s2, lv, pd;
    logic [CW-1:0] cnt;
    logic          accept, evt;

    assign accept = armed && (s2 != lv) && (cnt == CNT_LAST);
    assign evt    = accept && (s2 ? mode[2*g] : mode[2*g+1]);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        lv  <= 1'b0;
        cnt <= '0;
        pd  <= 1'b0;
      end else begin
        s1 <= in[g];
        s2 <= s1;
        // Set wins over a simultaneous clear so no event is lost.
        pd <= (pd & ~clear[g]) | evt;
        if (!armed) begin
          lv  <= s2;
          cnt <= '0;
        end else if (s2 == lv) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          lv  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign level[g]   = lv;
    assign pending[g] = pd;
  end

  assign irq      = |(pending & irq_mask);
  assign irq_edge = irq & ~irq_d;

  always_ff @(posedge clk) begin
    if (!rst_n) irq_d <= 1'b0;
    else        irq_d <= irq;
  end

endmodule

// File: tb/tb_edge_event_latch.sv
// Directed bench for edge_event_latch: expectations queued at drive time,
// popped and compared once the DUT latency has elapsed.
module tb_edge_event_latch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in;
  logic [15:0] mode;
  logic [7:0]  irq_mask;
  logic [7:0]  clear;
  logic [7:0]  level;
  logic [7:0]  pending;
  logic        irq;
  logic        irq_edge;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [7:0] lvl;
    logic [7:0] pnd;
    logic       iq;
    logic       ie;
  } exp_t;

  exp_t sb[$];

  edge_event_latch #(.WIDTH(8), .FILTER_LEN(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .mode     (mode),
    .irq_mask (irq_mask),
    .clear    (clear),
    .level    (level),
    .pending  (pending),
    .irq      (irq),
    .irq_edge (irq_edge)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] lvl, input logic [7:0] pnd,
                      input logic iq, input logic ie);
    exp_t e;
    e.tag = tag; e.lvl = lvl; e.pnd = pnd; e.iq = iq; e.ie = ie;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got size 0 exp >0");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (level === e.lvl) else begin
        errors++;
        $error("FAIL %s level got %h exp %h", e.tag, level, e.lvl);
      end
      checks++;
      assert (pending === e.pnd) else begin
        errors++;
        $error("FAIL %s pending got %h exp %h", e.tag, pending, e.pnd);
      end
      checks++;
      assert (irq === e.iq) else begin
        errors++;
        $error("FAIL %s irq got %b exp %b", e.tag, irq, e.iq);
      end
      checks++;
      assert (irq_edge === e.ie) else begin
        errors++;
        $error("FAIL %s irq_edge got %b exp %b", e.tag, irq_edge, e.ie);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in = 8'h01; mode = 16'h0000; irq_mask = 8'h00; clear = 8'h00;
    push("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    step(3); pop_check();

    // Arming with in[0] held high: level follows after 3 edges, no event.
    rst_n = 1'b1;
    push("arm_e2", 8'h00, 8'h00, 1'b0, 1'b0);
    step(2); pop_check();
    push("arm_e3", 8'h01, 8'h00, 1'b0, 1'b0);
    step(1); pop_check();

    // Drop in[0] with channel off: level falls, nothing pending.
    in = 8'h00;
    push("ch0_off_fall", 8'h00, 8'h00, 1'b0, 1'b0);
    step(6); pop_check();

    // Rising edge on channel 0: pending at E4, irq_edge for one cycle.
    mode = 16'h0001; irq_mask = 8'h01; in = 8'h01;
    push("rise_e3", 8'h00, 8'h00, 1'b0, 1'b0);
    push("rise_e4", 8'h01, 8'h01, 1'b1, 1'b1);
    push("rise_e5", 8'h01, 8'h01, 1'b1, 1'b0);
    step(4); pop_check();
    step(1); pop_check();
    step(1); pop_check();

    clear = 8'h01;
    push("clr_ch0", 8'h01, 8'h00, 1'b0, 1'b0);
    step(1); clear = 8'h00; pop_check();

    // Glitch filter on channel 1 (both edges): 2-clk pulse is discarded.
    mode = 16'h000D; in = 8'h03;
    push("glitch2", 8'h01, 8'h00, 1'b0, 1'b0);
    step(2); in = 8'h01;
    step(8); pop_check();

    // 3-clk pulse: accepted, rising sets pending, falling sets again.
    in = 8'h03;
    push("pulse3_rise", 8'h03, 8'h02, 1'b0, 1'b0);
    step(3); in = 8'h01;
    step(2); pop_check();
    clear = 8'h02;
    push("pulse3_clr", 8'h03, 8'h00, 1'b0, 1'b0);
    step(1); clear = 8'h00; pop_check();
    push("pulse3_e6", 8'h03, 8'h00, 1'b0, 1'b0);
    step(1); pop_check();
    push("pulse3_fall", 8'h01, 8'h02, 1'b0, 1'b0);
    step(1); pop_check();
    clear = 8'h02;
    step(1); clear = 8'h00;

    // Clear race on channel 2.
    mode = 16'h001D; in = 8'h05;
    push("ch2_rise", 8'h05, 8'h04, 1'b0, 1'b0);
    step(5); pop_check();
    mode = 16'h003D; in = 8'h01;
    push("race_pre", 8'h05, 8'h04, 1'b0, 1'b0);
    step(4); pop_check();
    clear = 8'h04;
    push("race_set_wins", 8'h01, 8'h04, 1'b0, 1'b0);
    step(1); clear = 8'h00; pop_check();
    clear = 8'h04;
    push("idle_clear", 8'h01, 8'h00, 1'b0, 1'b0);
    step(1); clear = 8'h00; pop_check();
    push("idle_clear_hold", 8'h01, 8'h00, 1'b0, 1'b0);
    step(1); pop_check();

    // Channel 3 mode 00: toggling never sets.
    in = 8'h09;
    push("ch3_off_hi", 8'h09, 8'h00, 1'b0, 1'b0);
    step(5); pop_check();
    in = 8'h01;
    push("ch3_off_lo", 8'h01, 8'h00, 1'b0, 1'b0);
    step(5); pop_check();

    // Channel 4 masked, then unmasked.
    mode = 16'h013D; in = 8'h11;
    push("ch4_masked", 8'h11, 8'h10, 1'b0, 1'b0);
    step(5); pop_check();
    irq_mask = 8'h11;
    push("ch4_unmask", 8'h11, 8'h10, 1'b1, 1'b1);
    step(0); pop_check();
    push("ch4_unmask_n1", 8'h11, 8'h10, 1'b1, 1'b0);
    step(1); pop_check();
    mode = 16'h003D;
    push("mode_keeps_pend", 8'h11, 8'h10, 1'b1, 1'b0);
    step(1); pop_check();

    // Reset while channel 5 filter counter is at 1.
    mode = 16'h043D; in = 8'h31;
    push("pre_reset", 8'h11, 8'h10, 1'b1, 1'b0);
    step(3); pop_check();
    rst_n = 1'b0;
    push("mid_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    step(1); pop_check();
    rst_n = 1'b1;
    push("rearm", 8'h31, 8'h00, 1'b0, 1'b0);
    push("rearm_stable", 8'h31, 8'h00, 1'b0, 1'b0);
    step(3); pop_check();
    step(6); pop_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edge_event_latch.md
# edge_event_latch

Multi-channel successor to the single-channel negedge event latch. Each of WIDTH asynchronous inputs is synchronised, glitch-filtered and edge-detected in the clk domain; qualifying edges set a sticky per-channel pending bit that software clears by write-1-to-clear. A combined, maskable interrupt and its one-cycle rising-edge pulse feed the CPLD interrupt controller.

## Interface
Parameters:
- WIDTH, 8: number of channels, 1..32.
- FILTER_LEN, 3: clk cycles a synchronised level must persist before it is accepted, 1..15. 1 = no filtering.

Ports:
- clk  input  1  system clock; sole clock of the block.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in  input  WIDTH  raw asynchronous event inputs.
- mode  input  2*WIDTH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- irq_mask  input  WIDTH  1 = channel contributes to irq.
- clear  input  WIDTH  single-cycle write-1-to-clear strobe for pending.
- level  output  WIDTH  filtered, synchronised input level.
- pending  output  WIDTH  sticky event flags.
- irq  output  1  OR of pending & irq_mask.
- irq_edge  output  1  one-cycle pulse when irq goes 0->1.

## Operation
- Per channel: 2-FF synchroniser (s1, s2) -> filter counter -> level register -> edge detect -> pending.
- Arming: 2-bit arm counter after reset. While not armed, level <= s2 every cycle, filter counters held at 0, no pending sets. armed asserts on the 3rd rising clk with rst_n high and stays set until reset.
- Filter (armed): if s2 == level, counter <= 0. Else if counter == FILTER_LEN-1, level <= s2 and counter <= 0. Else counter increments.
- A pulse shorter than FILTER_LEN cycles at s2 is discarded: counter restarts when s2 returns to level.
- Counter width: clog2(FILTER_LEN), at least 1 bit. It never wraps.
- Event when level changes, qualified by mode: rising (0->1) needs mode bit 0; falling (1->0) needs mode bit 1; mode 00 never sets.
- pending[i] next = (pending[i] & ~clear[i]) | event[i]. Set wins over a simultaneous clear, so no event is lost.
- Changing mode or irq_mask never alters pending. A masked pending bit stays set and raises irq as soon as it is unmasked.
- irq is combinational from registers: |(pending & irq_mask).
- irq_edge = irq & ~irq_d, where irq_d is irq registered. Asserted for exactly one cycle per irq 0->1 transition.
- Reset (rst_n low at a rising edge): s1, s2, level, counters, pending, arm counter and irq_d all go to 0. An in-progress filter count is discarded. Reset asserted mid-operation behaves identically to reset at power-up.

## Timing
- Reset values: level 0, pending 0, irq 0, irq_edge 0.
- In steady state (armed), in changes and is stable across rising edge E0:
  - s1 at E0, s2 at E1.
  - level and pending update at E(1+FILTER_LEN).
  - irq is valid in the same cycle as pending.
  - irq_edge is high from E(1+FILTER_LEN) to E(2+FILTER_LEN).
- With the default FILTER_LEN=3: 4 cycles from the sampling edge to pending.
- clear takes effect at the edge that samples it; pending reads 0 the next cycle unless a new event coincides.
- Inputs held constant through reset and arming produce no event.

## Test plan
- Arming: in=0x01 held through reset, rst_n released -> level=0x01 after 3 clk, pending stays 0x00, irq stays 0.
- Rising edge: mode[1:0]=01, irq_mask=0x01, in[0] 0->1 at E0 -> pending=0x01, level[0]=1 and irq=1 at E4; irq_edge high for one cycle only.
- Glitch filter: in[1] pulsed high for 2 clk with mode[3:2]=11 -> level[1] stays 0, pending=0x00. A 3-clk pulse -> pending[1]=1, set at its falling edge as well.
- Clear race: pending[2]=1, clear=0x04 in the same cycle as a new channel-2 event -> pending[2] remains 1. Clear in an idle cycle -> pending[2]=0 next cycle.
- Mask and mode: mode=00 on channel 3 with toggling in[3] -> no set. Set pending[4] with irq_mask[4]=0 -> irq=0; then set irq_mask[4]=1 -> irq=1 and one irq_edge pulse.
- Reset mid-filter: rst_n low while the channel-5 filter counter is at 1 -> all outputs 0 the next cycle; after re-arming, a stable in[5]=1 yields no event.
